prbs_generator: RTL

PRBS_GENERATOR -- requirements
Module: prbs_generator

---
 rtl/prbs_generator_if.sv | 49 ++++
 rtl/prbs_generator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/prbs_generator_if.sv
// Stream bundle between the PRBS generator (master) and its consumer/monitor (slave).
// Control inputs, the presented word with its valid/ready handshake, and status.
interface prbs_generator_if #(
  parameter int OUTLENGTH = 8
);

  localparam int SEL_W = (OUTLENGTH > 1) ? $clog2(OUTLENGTH) : 1;

  logic                 enable;
  logic                 seed_load;
  logic [OUTLENGTH-1:0] seed;
  logic [7:0]           burst_len;
  logic                 inject_err;
  logic [SEL_W-1:0]     err_bit_sel;
  logic                 out_ready;
  logic [OUTLENGTH-1:0] LFSR;
  logic                 out_valid;
  logic                 burst_done;
  logic [15:0]          word_count;

  modport master (
    input  enable,
    input  seed_load,
    input  seed,
    input  burst_len,
    input  inject_err,
    input  err_bit_sel,
    input  out_ready,
    output LFSR,
    output out_valid,
    output burst_done,
    output word_count
  );

  modport slave (
    output enable,
    output seed_load,
    output seed,
    output burst_len,
    output inject_err,
    output err_bit_sel,
    output out_ready,
    input  LFSR,
    input  out_valid,
    input  burst_done,
    input  word_count
  );

endinterface

// File: rtl/prbs_generator.sv
// PRBS word generator: 8-bit XNOR LFSR (taps 3,2,1 into bit 0) presented over a
// valid/ready handshake, with optional fixed-length bursts, single-bit error
// injection on the driven word, and a saturating count of accepted words.
module prbs_generator #(
  parameter int OUTLENGTH = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  prbs_generator_if.master  bus
);

  localparam int SEL_W = (OUTLENGTH > 1) ? $clog2(OUTLENGTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t               state_q;
  logic [OUTLENGTH-1:0] lfsr_q;
  logic [OUTLENGTH-1:0] lfsr_out_q;
  logic                 out_valid_q;
  logic                 burst_done_q;
  logic [15:0]          word_count_q;
  logic [7:0]           burst_cnt_q;
  logic                 burst_wait_q;
  logic                 armed_q;
  logic [SEL_W-1:0]     sel_q;

  logic                 transfer;
  logic [OUTLENGTH-1:0] lfsr_step;
  logic [OUTLENGTH-1:0] lfsr_d;
  logic                 armed_d;
  logic [SEL_W-1:0]     sel_d;
  logic [OUTLENGTH-1:0] err_mask;

  assign transfer  = out_valid_q & bus.out_ready;
  assign lfsr_step = {lfsr_q[OUTLENGTH-2:0], ~(lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1])};

  // Next internal word and error-arming state; seed_load overrides everything, and an
  // inject on a transfer edge re-arms for the word that follows.
  always_comb begin
    lfsr_d   = lfsr_q;
    armed_d  = armed_q;
    sel_d    = sel_q;
    if (bus.seed_load) begin
      lfsr_d  = bus.seed;
      armed_d = 1'b0;
    end else begin
      if (transfer) begin
        lfsr_d  = lfsr_step;
        armed_d = 1'b0;
      end
      if (bus.inject_err) begin
        armed_d = 1'b1;
        sel_d   = bus.err_bit_sel;
      end
    end
    err_mask = armed_d ? (OUTLENGTH'(1) << sel_d) : '0;
  end

  // Register the clean LFSR state and, separately, the driven word with any armed error,
  // so injected errors never feed back into the sequence.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lfsr_q     <= '0;
      lfsr_out_q <= '0;
      armed_q    <= 1'b0;
      sel_q      <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      lfsr_out_q <= lfsr_d ^ err_mask;
      armed_q    <= armed_d;
      sel_q      <= sel_d;
    end
  end

  // Handshake FSM with burst counting, re-enable lockout after a finished burst,
  // and a saturating accepted-word counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
      word_count_q <= '0;
      burst_cnt_q  <= '0;
      burst_wait_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      if (!bus.enable) begin
        burst_wait_q <= 1'b0;
      end
      if (bus.seed_load) begin
        state_q      <= IDLE;
        out_valid_q  <= 1'b0;
        word_count_q <= '0;
      end else begin
        if (transfer && (word_count_q != 16'hFFFF)) begin
          word_count_q <= word_count_q + 16'd1;
        end
        case (state_q)
          IDLE: begin
            out_valid_q <= 1'b0;
            if (bus.enable && !burst_wait_q) begin
              state_q     <= RUN;
              out_valid_q <= 1'b1;
              burst_cnt_q <= bus.burst_len;
            end
          end
          RUN, STALL: begin
            if (transfer) begin
              if (burst_cnt_q == 8'd1) begin
                state_q      <= IDLE;
                out_valid_q  <= 1'b0;
                burst_done_q <= 1'b1;
                burst_cnt_q  <= '0;
                burst_wait_q <= 1'b1;
              end else begin
                if (burst_cnt_q != 8'd0) begin
                  burst_cnt_q <= burst_cnt_q - 8'd1;
                end
                if (!bus.enable) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                end else begin
                  state_q <= RUN;
                end
              end
            end else begin
              state_q <= STALL;
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.LFSR       = lfsr_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.burst_done = burst_done_q;
  assign bus.word_count = word_count_q;

endmodule
